// File: rtl/prio_pkg.sv
// Shared constants and helpers for the pending-request priority encoder.
package prio_pkg;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    function automatic int prio_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: first set bit found searching downward from start_i, wrapping at 0.
module prio_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    always_comb begin
        int pos;
        idx_o   = '0;
        found_o = 1'b0;
        pos     = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(start_i) - i;
            if (pos < 0) pos = pos + N;
            if (!found_o && vec_i[W'(pos)]) begin
                found_o = 1'b1;
                idx_o   = W'(pos);
            end
        end
    end

endmodule

// File: rtl/pending_prio_encoder.sv
// Accumulates request bits into a pending set and issues one index per valid/ready transfer,
// in fixed-priority or round-robin order.
module pending_prio_encoder
    import prio_pkg::*;
#(
    parameter int N  = 8,
    parameter int RR = PRIO_FIXED,
    parameter int W  = prio_clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic         req_vld,
    output logic [W-1:0] out_idx,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [N-1:0] pending,
    output logic [7:0]   merge_cnt
);

    localparam logic [N-1:0] ONE_N = N'(1);

    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic         out_vld_q, out_vld_d;
    logic [W-1:0] last_q, last_d;
    logic [7:0]   merge_cnt_q, merge_cnt_d;

    logic [N-1:0] cand;
    logic [N-1:0] held;
    logic [N-1:0] hit;
    logic [7:0]   merge_pop;
    logic [W-1:0] start;
    logic [W-1:0] pick;
    logic         found;
    logic         load;

    // After reset last_q=0 so the round-robin search starts at N-1, same as fixed mode.
    always_comb begin
        if (RR == PRIO_RR) begin
            start = (last_q == '0) ? W'(N - 1) : last_q - W'(1);
        end else begin
            start = W'(N - 1);
        end
    end

    prio_pick #(.N(N), .W(W)) u_pick (
        .vec_i  (cand),
        .start_i(start),
        .idx_o  (pick),
        .found_o(found)
    );

    always_comb begin
        cand = pending_q | (req_vld ? req_in : '0);
        held = out_vld_q ? (ONE_N << out_idx_q) : '0;
        hit  = req_vld ? (req_in & (pending_q | held)) : '0;
        load = !out_vld_q || out_rdy;

        merge_pop = '0;
        for (int i = 0; i < N; i++) begin
            merge_pop = merge_pop + 8'(hit[i]);
        end
    end

    always_comb begin
        pending_d   = cand;
        out_idx_d   = out_idx_q;
        out_vld_d   = out_vld_q;
        last_d      = last_q;
        merge_cnt_d = sat_add8(merge_cnt_q, merge_pop);
        if (load) begin
            out_vld_d = found;
            if (found) begin
                out_idx_d = pick;
                last_d    = pick;
                pending_d = cand & ~(ONE_N << pick);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            out_idx_q   <= '0;
            out_vld_q   <= 1'b0;
            last_q      <= '0;
            merge_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            out_idx_q   <= out_idx_d;
            out_vld_q   <= out_vld_d;
            last_q      <= last_d;
            merge_cnt_q <= merge_cnt_d;
        end
    end

    assign pending   = pending_q;
    assign out_idx   = out_idx_q;
    assign out_vld   = out_vld_q;
    assign merge_cnt = merge_cnt_q;

endmodule

// File: tb/tb_pending_prio_encoder.sv
// Scoreboard bench: fixed-priority and round-robin instances driven by shared stimulus.
module tb_pending_prio_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_in = '0;
    logic       req_vld = 1'b0;
    logic       out_rdy = 1'b0;

    logic [2:0] o_idx[2];
    logic       o_vld[2];
    logic [7:0] o_pend[2];
    logic [7:0] o_merge[2];

    int n_checks = 0;
    int n_errors = 0;

    // behavioural reference state, index 0 = fixed priority, 1 = round-robin
    logic [7:0] m_pend[2];
    logic       m_vld[2];
    int         m_idx[2];
    int         m_last[2];
    int         m_merge[2];
    int         expq0[$], expq1[$];
    int         obs0[$], obs1[$];

    always #5 clk = ~clk;

    pending_prio_encoder #(.N(8), .RR(0)) u_fixed (
        .clk(clk), .rst(rst), .req_in(req_in), .req_vld(req_vld),
        .out_idx(o_idx[0]), .out_vld(o_vld[0]), .out_rdy(out_rdy),
        .pending(o_pend[0]), .merge_cnt(o_merge[0])
    );

    pending_prio_encoder #(.N(8), .RR(1)) u_rr (
        .clk(clk), .rst(rst), .req_in(req_in), .req_vld(req_vld),
        .out_idx(o_idx[1]), .out_vld(o_vld[1]), .out_rdy(out_rdy),
        .pending(o_pend[1]), .merge_cnt(o_merge[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0; m_vld[m] = 1'b0; m_idx[m] = 0; m_last[m] = 0; m_merge[m] = 0;
        end
        expq0.delete(); expq1.delete(); obs0.delete(); obs1.delete();
    endtask

    task automatic model_step(input int m, input logic [7:0] r, input logic v, input logic rd);
        logic [7:0] c;
        int merges, start, p, b;
        c = m_pend[m] | (v ? r : 8'h00);
        merges = 0;
        if (v) begin
            for (int k = 0; k < 8; k++) begin
                if (r[k] && (m_pend[m][k] || (m_vld[m] && m_idx[m] == k))) merges++;
            end
        end
        m_merge[m] = (m_merge[m] + merges > 255) ? 255 : m_merge[m] + merges;
        if (!m_vld[m] || rd) begin
            if (c != 0) begin
                start = (m == 1) ? (m_last[m] + 7) % 8 : 7;
                p = -1;
                for (int k = 0; k < 8; k++) begin
                    b = (start - k + 8) % 8;
                    if (p < 0 && c[b]) p = b;
                end
                c[p] = 1'b0;
                m_idx[m] = p; m_vld[m] = 1'b1; m_last[m] = p;
                if (m == 0) expq0.push_back(p); else expq1.push_back(p);
            end else begin
                m_vld[m] = 1'b0;
            end
        end
        m_pend[m] = c;
    endtask

    // one clock cycle with the given inputs; the model advances right after the edge
    task automatic cyc(input logic [7:0] r, input logic v, input logic rd);
        req_in = r; req_vld = v; out_rdy = rd;
        @(posedge clk); #1;
        model_step(0, r, v, rd);
        model_step(1, r, v, rd);
    endtask

    task automatic do_reset();
        req_in = '0; req_vld = 1'b0; out_rdy = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rst_vld%0d", m), o_vld[m], 0);
            chk($sformatf("rst_idx%0d", m), o_idx[m], 0);
            chk($sformatf("rst_pend%0d", m), o_pend[m], 0);
            chk($sformatf("rst_merge%0d", m), o_merge[m], 0);
        end
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic chk_obs(input string name, input int m, input int n,
                           input int e0, input int e1, input int e2, input int e3, input int e4);
        int e[5];
        int got;
        e = '{e0, e1, e2, e3, e4};
        got = (m == 0) ? obs0.size() : obs1.size();
        if (got < n) begin
            chk({name, "_len"}, got, n);
        end else begin
            for (int k = 0; k < n; k++) begin
                chk($sformatf("%s[%0d]", name, k), (m == 0) ? obs0[k] : obs1[k], e[k]);
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 12; k++) cyc(8'h00, 1'b0, 1'b1);
        obs0.delete(); obs1.delete();
    endtask

    // monitor: per-cycle state comparison and scoreboard pop on every transfer
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int m = 0; m < 2; m++) begin
                    chk($sformatf("vld%0d", m), o_vld[m], m_vld[m]);
                    chk($sformatf("idx%0d", m), o_idx[m], m_idx[m]);
                    chk($sformatf("pend%0d", m), o_pend[m], m_pend[m]);
                    chk($sformatf("merge%0d", m), o_merge[m], m_merge[m]);
                    if (o_vld[m] && out_rdy) begin
                        if (m == 0) begin
                            if (expq0.size() == 0) chk("sb0_empty", 1, 0);
                            else chk("sb0", o_idx[0], expq0.pop_front());
                            obs0.push_back(int'(o_idx[0]));
                        end else begin
                            if (expq1.size() == 0) chk("sb1_empty", 1, 0);
                            else chk("sb1", o_idx[1], expq1.pop_front());
                            obs1.push_back(int'(o_idx[1]));
                        end
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        @(posedge clk); #1 rst = 1'b0;

        // fixed: two bits in one strobe drain highest first
        cyc(8'b1100_0000, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) cyc(8'h00, 1'b0, 1'b1);
        chk_obs("t1_order", 0, 2, 7, 6, 0, 0, 0);
        chk("t1_vld", o_vld[0], 0);
        chk("t1_pend", o_pend[0], 0);
        drain();

        // consumer stalled: output holds, remaining bits wait
        cyc(8'b0011_0011, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(8'h00, 1'b0, 1'b0);
            chk("t2_idx_hold", o_idx[0], 5);
            chk("t2_pend", o_pend[0], 8'b0001_0011);
        end
        for (int k = 0; k < 5; k++) cyc(8'h00, 1'b0, 1'b1);
        chk_obs("t2_order", 0, 4, 5, 4, 1, 0, 0);
        drain();

        // merge counting and saturation
        cyc(8'b0001_0010, 1'b1, 1'b0);
        cyc(8'b0001_0010, 1'b1, 1'b0);
        chk("t3_merge2", o_merge[0], 2);
        for (int k = 0; k < 300; k++) cyc(8'b0001_0010, 1'b1, 1'b0);
        chk("t3_sat", o_merge[0], 255);
        drain();

        // asynchronous reset with pending state
        cyc(8'b0000_1111, 1'b1, 1'b0);
        chk("t4_pend_pre", o_pend[0], 8'b0000_0111);
        do_reset();

        // round-robin rotation with a persistent request
        for (int k = 0; k < 5; k++) cyc(8'b0110_0110, 1'b1, 1'b1);
        cyc(8'h00, 1'b0, 1'b1);
        chk_obs("t5_rr", 1, 5, 6, 5, 2, 1, 6);
        drain();

        // re-request of the held index during its transfer
        cyc(8'b0100_0000, 1'b1, 1'b0);
        cyc(8'b0100_0100, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) cyc(8'h00, 1'b0, 1'b1);
        chk_obs("t6_rr", 1, 3, 6, 2, 6, 0, 0);
        chk_obs("t6_fix", 0, 3, 6, 6, 2, 0, 0);
        drain();

        // randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cyc(8'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 7));
            end
        end
        drain();
        chk("end_q0", expq0.size(), 0);
        chk("end_q1", expq1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
